// File: rtl/encoder4to2_pkg.sv
// Shared widths, index type and reference priority encoder for the 4-to-2 encoder family.
package encoder4to2_pkg;

  localparam int IN_W  = 4;
  localparam int OUT_W = 2;

  typedef logic [OUT_W-1:0] enc_idx_t;

  // Highest set bit wins; an all-zero vector also returns 0, so callers need any-set to tell it from bit 0.
  function automatic enc_idx_t prio_encode(logic [IN_W-1:0] req);
    enc_idx_t idx;
    if (req[3])      idx = 2'b11;
    else if (req[2]) idx = 2'b10;
    else if (req[1]) idx = 2'b01;
    else             idx = 2'b00;
    return idx;
  endfunction

endpackage

// File: rtl/encoder4to2_core.sv
// Purpose: combinational 4-to-2 priority encoder, bit 3 highest priority, with an any-set flag.
// Latency: 0 cycles.
// Backpressure: none; the result follows the request vector continuously.
module encoder4to2_core
  import encoder4to2_pkg::*;
(
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] idx,
  output logic             any_set
);

  always_comb begin
    idx = 2'b00;
    if (in[3])      idx = 2'b11;
    else if (in[2]) idx = 2'b10;
    else if (in[1]) idx = 2'b01;
    else            idx = 2'b00;
  end

  assign any_set = |in;

endmodule

// File: rtl/encoder4to2_ifelse.sv
// Purpose: 4-to-2 priority encoder with valid flag; optional multi-hot err (ENCODER4TO2_MULTI_HOT_ERR_EN).
// Latency: 1 cycle with REG_OUT=1, 0 cycles with REG_OUT=0.
// Backpressure: none; a new result is produced every cycle and is never stalled.
module encoder4to2_ifelse
  import encoder4to2_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             valid
`ifdef ENCODER4TO2_MULTI_HOT_ERR_EN
  ,
  output logic             err
`endif
);

  logic [OUT_W-1:0] idx;
  logic             any_set;

  encoder4to2_core u_core (
    .in      (in),
    .idx     (idx),
    .any_set (any_set)
  );

`ifdef ENCODER4TO2_MULTI_HOT_ERR_EN
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  logic multi_hot;
  assign multi_hot = |(in & (in - 4'd1));
`endif

  if (REG_OUT) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out   <= 2'b00;
        valid <= 1'b0;
      end else begin
        out   <= idx;
        valid <= any_set;
      end
    end

`ifdef ENCODER4TO2_MULTI_HOT_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
      if (rst) err <= 1'b0;
      else     err <= multi_hot;
    end
`endif
  end else begin : g_comb
    // Pass-through build: clock and reset are intentionally left without a load.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign out   = idx;
    assign valid = any_set;
`ifdef ENCODER4TO2_MULTI_HOT_ERR_EN
    assign err   = multi_hot;
`endif
  end

endmodule

// File: tb/tb_encoder4to2_ifelse.sv
// Bench for encoder4to2_ifelse: registered instance checked through a scoreboard, pass-through instance checked in-cycle.
module tb_encoder4to2_ifelse;

`ifdef ENCODER4TO2_MULTI_HOT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] in_v;
  logic [1:0] out_r, out_c;
  logic       valid_r, valid_c;
  logic       err_r, err_c;

  int total = 0;
  int bad   = 0;

  logic [3:0] sb_q[$];

  logic [1:0]  out_tab [16] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                                2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
  logic [15:0] valid_bits = 16'hFFFE;
  logic [15:0] err_bits   = 16'b1111_1110_1110_1000;

  encoder4to2_ifelse #(.REG_OUT(1'b1)) dut_r (
    .clk   (clk),
    .rst   (rst),
    .in    (in_v),
    .out   (out_r),
    .valid (valid_r)
`ifdef ENCODER4TO2_MULTI_HOT_ERR_EN
    ,
    .err   (err_r)
`endif
  );

  encoder4to2_ifelse #(.REG_OUT(1'b0)) dut_c (
    .clk   (clk),
    .rst   (rst),
    .in    (in_v),
    .out   (out_c),
    .valid (valid_c)
`ifdef ENCODER4TO2_MULTI_HOT_ERR_EN
    ,
    .err   (err_c)
`endif
  );

`ifndef ENCODER4TO2_MULTI_HOT_ERR_EN
  assign err_r = 1'b0;
  assign err_c = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compared value is packed as {err, valid, out}.
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got err/valid/out=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] pack_exp(logic [1:0] eo, logic ev, logic ee);
    return {ERR_EN & ee, ev, eo};
  endfunction

  // Drive in mid-cycle, check the pass-through copy at once, queue the registered expectation at the capture edge.
  task automatic apply(input logic [3:0] v, input logic [1:0] eo, input logic ev, input logic ee);
    @(negedge clk);
    in_v = v;
    #1;
    check("comb", {err_c, valid_c, out_c}, pack_exp(eo, ev, ee));
    @(posedge clk);
    sb_q.push_back(pack_exp(eo, ev, ee));
  endtask

  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("reg", {err_r, valid_r, out_r}, e);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst  = 1'b1;
    in_v = 4'b1000;
    #1;
    check("reset_state", {err_r, valid_r, out_r}, 4'b0000);
    check("comb_in_reset", {err_c, valid_c, out_c}, pack_exp(2'b11, 1'b1, 1'b0));

    // Release between edges: outputs hold until the first rising edge registers in.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_release", {err_r, valid_r, out_r}, 4'b0000);
    @(posedge clk);
    #1;
    check("first_edge", {err_r, valid_r, out_r}, pack_exp(2'b11, 1'b1, 1'b0));

    // Asynchronous assert mid-cycle clears immediately and holds across edges.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_clear", {err_r, valid_r, out_r}, 4'b0000);
    check("comb_ignores_rst", {err_c, valid_c, out_c}, pack_exp(2'b11, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    check("held_in_reset", {err_r, valid_r, out_r}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // A request present when reset hits is never reported.
    in_v = 4'b0110;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("discard_pending", {err_r, valid_r, out_r}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // One-hot sweep, each held two cycles.
    apply(4'b0001, 2'b00, 1'b1, 1'b0);
    apply(4'b0001, 2'b00, 1'b1, 1'b0);
    apply(4'b0010, 2'b01, 1'b1, 1'b0);
    apply(4'b0010, 2'b01, 1'b1, 1'b0);
    apply(4'b0100, 2'b10, 1'b1, 1'b0);
    apply(4'b0100, 2'b10, 1'b1, 1'b0);
    apply(4'b1000, 2'b11, 1'b1, 1'b0);
    apply(4'b1000, 2'b11, 1'b1, 1'b0);

    // Idle versus bit 0, back to back.
    apply(4'b0000, 2'b00, 1'b0, 1'b0);
    apply(4'b0001, 2'b00, 1'b1, 1'b0);

    // Multi-hot.
    apply(4'b0011, 2'b01, 1'b1, 1'b1);
    apply(4'b1111, 2'b11, 1'b1, 1'b1);
    apply(4'b0110, 2'b10, 1'b1, 1'b1);
    apply(4'b0100, 2'b10, 1'b1, 1'b0);

    // Exhaustive, new value every cycle.
    for (int i = 0; i < 16; i++) begin
      apply(i[3:0], out_tab[i], valid_bits[i], err_bits[i]);
    end

    @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results still pending, required 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
